ccff_frame_loader: RTL and testbench

- Programming-side configuration stage that loads the select bits for the routing and LUT mux trees.
- Receives a serial configuration frame and shifts it into a chain register, then checks an even-parity bit.
- Commits the frame atomically to a shadow register that drives the mux sram ports.
- Mux selects never glitch during shifting; a corrupted frame never reaches the fabric. The shifted-out bit is forwarded for daisy-chaining to the next loader.

---
 rtl/ccff_frame_loader.sv | 127 ++++++++++++
 tb/tb_ccff_frame_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ccff_frame_loader.sv
// Serial configuration frame loader: shifts a frame into a chain register, checks
// even parity, and atomically commits it to a shadow register driving mux selects.
module ccff_frame_loader #(
  parameter int unsigned NUM_BITS  = 16,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                cfg_start,
  input  logic                cfg_bit_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic [0:NUM_BITS-1] mem_out,
  output logic [0:NUM_BITS-1] mem_outb,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int unsigned CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [0:NUM_BITS-1] sr_q, sr_d;
  logic [0:NUM_BITS-1] mem_q, mem_d;
  logic [0:NUM_BITS-1] memb_q;
  logic                pbit_q, pbit_d;
  logic                tail_q, tail_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q;
  logic                accept;
  logic                last_bit;
  logic                parity_ok;

  assign accept    = ready_q && cfg_bit_valid;
  assign last_bit  = (count_q == CNT_W'(NUM_BITS - 1));
  assign parity_ok = !PARITY_EN || ((^sr_q ^ pbit_q) == 1'b0);

  // Next-state: cfg_start outranks a same-cycle bit in SHIFT/PARITY, ignored in COMMIT.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;
    mem_d   = mem_q;
    pbit_d  = pbit_q;
    tail_d  = tail_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (cfg_start) begin
          count_d = '0;
        end else if (accept) begin
          sr_d   = {sr_q[1:NUM_BITS-1], cfg_bit};
          tail_d = sr_q[0];
          if (last_bit) begin
            state_d = PARITY_EN ? PARITY : COMMIT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (cfg_start) begin
          state_d = SHIFT;
          count_d = '0;
        end else if (accept) begin
          pbit_d  = cfg_bit;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (parity_ok) begin
          mem_d  = sr_q;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sr_q    <= '0;
      mem_q   <= '0;
      memb_q  <= '1;
      pbit_q  <= 1'b0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      mem_q   <= mem_d;
      memb_q  <= ~mem_d;
      pbit_q  <= pbit_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= (state_d == SHIFT) || (state_d == PARITY);
    end
  end

  assign cfg_ready = ready_q;
  assign mem_out   = mem_q;
  assign mem_outb  = memb_q;
  assign ccff_tail = tail_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_ccff_frame_loader.sv
// Directed bench for ccff_frame_loader: a 16-bit parity instance and a 4-bit
// no-parity instance, with hand-computed expected values.
module tb_ccff_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_start = 1'b0, a_valid = 1'b0, a_bit = 1'b0;
  logic        a_ready, a_tail, a_done, a_err;
  logic [0:15] a_mem, a_memb;
  logic        b_start = 1'b0, b_valid = 1'b0, b_bit = 1'b0;
  logic        b_ready, b_tail, b_done, b_err;
  logic [0:3]  b_mem, b_memb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ccff_frame_loader #(.NUM_BITS(16), .PARITY_EN(1'b1)) dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(a_start),
    .cfg_bit_valid(a_valid), .cfg_bit(a_bit), .cfg_ready(a_ready),
    .mem_out(a_mem), .mem_outb(a_memb), .ccff_tail(a_tail),
    .cfg_done(a_done), .cfg_err(a_err));

  ccff_frame_loader #(.NUM_BITS(4), .PARITY_EN(1'b0)) dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(b_start),
    .cfg_bit_valid(b_valid), .cfg_bit(b_bit), .cfg_ready(b_ready),
    .mem_out(b_mem), .mem_outb(b_memb), .ccff_tail(b_tail),
    .cfg_done(b_done), .cfg_err(b_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic b);
    a_valid = 1'b1;
    a_bit   = b;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic a_begin();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    a_begin();
    a_send(1'b1);
    a_send(1'b1);
    a_send(1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_mem !== 16'h0000) begin n_err++; $display("FAIL reset_mem: got %h want 0000", a_mem); end
    n_cmp++; if (a_memb !== 16'hFFFF) begin n_err++; $display("FAIL reset_memb: got %h want ffff", a_memb); end
    n_cmp++; if ({a_ready, a_done, a_err, a_tail} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {a_ready, a_done, a_err, a_tail}); end
    tick();
    rst_n = 1'b1;
    tick();
    a_valid = 1'b1;
    a_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", a_ready); end
    end
    a_valid = 1'b0;
    n_cmp++; if ({a_done, a_err} !== 2'b00 || a_mem !== 16'h0000) begin n_err++; $display("FAIL idle_no_commit: got %b %h want 00 0000", {a_done, a_err}, a_mem); end
  endtask

  task automatic test_good_frame();
    a_begin();
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL good_ready: got %b want 1", a_ready); end
    for (int k = 0; k < 16; k++) a_send((k % 2) == 0);
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL good_parity_ready: got %b want 1", a_ready); end
    a_send(1'b0);
    n_cmp++; if ({a_ready, a_done, a_mem} !== {2'b00, 16'h0000}) begin n_err++; $display("FAIL good_commit_cycle: got %b %b %h want 0 0 0000", a_ready, a_done, a_mem); end
    tick();
    n_cmp++; if ({a_done, a_err} !== 2'b10) begin n_err++; $display("FAIL good_pulse: got %b want 10", {a_done, a_err}); end
    n_cmp++; if (a_mem !== 16'hAAAA) begin n_err++; $display("FAIL good_mem: got %h want aaaa", a_mem); end
    n_cmp++; if (a_memb !== 16'h5555) begin n_err++; $display("FAIL good_memb: got %h want 5555", a_memb); end
    tick();
    n_cmp++; if ({a_done, a_err} !== 2'b00) begin n_err++; $display("FAIL good_pulse_end: got %b want 00", {a_done, a_err}); end
  endtask

  task automatic test_bad_parity();
    a_begin();
    for (int k = 0; k < 16; k++) a_send(1'b1);
    a_send(1'b1);
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL bad_early_err: got %b want 0", a_err); end
    tick();
    n_cmp++; if ({a_done, a_err} !== 2'b01) begin n_err++; $display("FAIL bad_pulse: got %b want 01", {a_done, a_err}); end
    n_cmp++; if (a_mem !== 16'hAAAA) begin n_err++; $display("FAIL bad_mem_hold: got %h want aaaa", a_mem); end
    tick();
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL bad_pulse_end: got %b want 0", a_err); end
  endtask

  task automatic test_stall_chain();
    a_begin();
    for (int k = 0; k < 16; k++) begin
      a_send((k % 2) == 0);
      tick();
      if (k == 5 || k == 15) begin
        n_cmp++; if ({a_ready, a_done} !== 2'b10) begin n_err++; $display("FAIL stall_gap_%0d: got %b want 10", k, {a_ready, a_done}); end
      end
    end
    a_send(1'b0);
    tick();
    n_cmp++; if ({a_done, a_mem} !== {1'b1, 16'hAAAA}) begin n_err++; $display("FAIL stall_commit: got %b %h want 1 aaaa", a_done, a_mem); end
    a_begin();
    for (int k = 0; k < 16; k++) begin
      a_send(1'b0);
      n_cmp++; if (a_tail !== ((k % 2) == 0)) begin n_err++; $display("FAIL chain_tail_%0d: got %b want %b", k, a_tail, (k % 2) == 0); end
    end
    a_send(1'b0);
    tick();
    n_cmp++; if ({a_done, a_mem, a_memb} !== {1'b1, 16'h0000, 16'hFFFF}) begin n_err++; $display("FAIL chain_zero_commit: got %b %h %h want 1 0000 ffff", a_done, a_mem, a_memb); end
  endtask

  task automatic test_abort();
    a_begin();
    for (int k = 0; k < 7; k++) a_send(1'b0);
    a_start = 1'b1;
    a_valid = 1'b1;
    a_bit   = 1'b0;
    tick();
    a_start = 1'b0;
    a_valid = 1'b0;
    for (int k = 0; k < 15; k++) a_send(1'b1);
    n_cmp++; if ({a_ready, a_done} !== 2'b10) begin n_err++; $display("FAIL abort_before_last: got %b want 10", {a_ready, a_done}); end
    a_send(1'b1);
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL abort_parity_state: got %b want 1", a_ready); end
    a_send(1'b0);
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL abort_commit_state: got %b want 0", a_ready); end
    tick();
    n_cmp++; if ({a_done, a_err, a_mem} !== {2'b10, 16'hFFFF}) begin n_err++; $display("FAIL abort_commit: got %b %h want 10 ffff", {a_done, a_err}, a_mem); end
  endtask

  task automatic test_no_parity();
    logic [3:0] bits;
    bits = 4'b1101;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1;
      b_bit   = bits[3-k];
      tick();
      b_valid = 1'b0;
    end
    n_cmp++; if ({b_ready, b_done} !== 2'b00) begin n_err++; $display("FAIL np_commit_cycle: got %b want 00", {b_ready, b_done}); end
    tick();
    n_cmp++; if ({b_done, b_err} !== 2'b10) begin n_err++; $display("FAIL np_pulse: got %b want 10", {b_done, b_err}); end
    n_cmp++; if ({b_mem, b_memb} !== 8'b1101_0010) begin n_err++; $display("FAIL np_mem: got %b %b want 1101 0010", b_mem, b_memb); end
    n_cmp++; if (b_tail !== 1'b0) begin n_err++; $display("FAIL np_tail: got %b want 0", b_tail); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_stall_chain();
    test_abort();
    test_no_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
